// File: rtl/ibex_fetch_req_engine.sv
// Instruction-fetch bus initiator: issues word-aligned OBI requests, tracks outstanding
// transactions, drops responses made stale by branches and pushes the rest into the fetch FIFO.
module ibex_fetch_req_engine #(
    parameter int unsigned NUM_REQS = 2
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                req_i,
    input  logic                branch_i,
    input  logic [31:0]         addr_i,
    output logic                busy_o,
    input  logic [NUM_REQS-1:0] fifo_busy_i,
    output logic                fifo_clear_o,
    output logic                fifo_valid_o,
    output logic [31:0]         fifo_addr_o,
    output logic [31:0]         fifo_rdata_o,
    output logic                fifo_err_o,
    output logic                instr_req_o,
    input  logic                instr_gnt_i,
    output logic [31:0]         instr_addr_o,
    input  logic                instr_rvalid_i,
    input  logic [31:0]         instr_rdata_i,
    input  logic                instr_err_i
);

    typedef enum logic [0:0] {
        IDLE,
        WAIT_GNT
    } state_e;

    state_e state_q, state_d;

    logic [NUM_REQS-1:0] outstanding_q, outstanding_d;
    logic [NUM_REQS-1:0] discard_q, discard_d;
    logic [NUM_REQS-1:0] outstanding_shift, discard_shift, new_slot;
    logic [31:0]         fetch_addr_q, fetch_addr_d;
    logic [31:0]         stored_addr_q, stored_addr_d;
    logic                stored_pend_q, stored_pend_d;
    logic [31:0]         branch_addr, idle_addr;
    logic                full, fifo_block, issue_ok;
    logic                gnt_acc, rvalid_acc, new_discard;

    assign branch_addr = {addr_i[31:2], 2'b00};
    assign gnt_acc     = instr_req_o & instr_gnt_i;
    assign rvalid_acc  = instr_rvalid_i & outstanding_q[0];

    // A response arriving this cycle frees the oldest slot, so issue may share the cycle.
    assign full       = outstanding_q[NUM_REQS-1] & ~instr_rvalid_i;
    assign fifo_block = (&fifo_busy_i) & ~branch_i;
    assign issue_ok   = req_i & ~fifo_block & ~full;

    // stored_pend_q means a branch landed while a stale request was waiting for grant.
    assign idle_addr = branch_i      ? branch_addr   :
                       stored_pend_q ? stored_addr_q : fetch_addr_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            outstanding_q <= '0;
            discard_q     <= '0;
            fetch_addr_q  <= '0;
            stored_addr_q <= '0;
            stored_pend_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            fetch_addr_q  <= fetch_addr_d;
            stored_addr_q <= stored_addr_d;
            stored_pend_q <= stored_pend_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        instr_req_o   = 1'b0;
        instr_addr_o  = fetch_addr_q;
        fetch_addr_d  = fetch_addr_q;
        stored_addr_d = stored_addr_q;
        stored_pend_d = stored_pend_q;
        new_discard   = 1'b0;
        case (state_q)
            IDLE: begin
                instr_req_o   = issue_ok;
                instr_addr_o  = idle_addr;
                fetch_addr_d  = idle_addr;
                stored_pend_d = 1'b0;
                if (issue_ok) begin
                    if (instr_gnt_i) begin
                        fetch_addr_d = idle_addr + 32'd4;
                    end else begin
                        state_d = WAIT_GNT;
                    end
                end
            end
            WAIT_GNT: begin
                // Address must not change until granted, even if the core redirects.
                instr_req_o  = 1'b1;
                instr_addr_o = fetch_addr_q;
                new_discard  = branch_i | stored_pend_q;
                if (branch_i) begin
                    stored_addr_d = branch_addr;
                    stored_pend_d = 1'b1;
                end
                if (instr_gnt_i) begin
                    fetch_addr_d = fetch_addr_q + 32'd4;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Retire the oldest entry first, then allocate the lowest free slot for a new grant.
    always_comb begin
        outstanding_shift = rvalid_acc ? (outstanding_q >> 1) : outstanding_q;
        discard_shift     = rvalid_acc ? (discard_q >> 1) : discard_q;
        new_slot          = '0;
        if (gnt_acc) begin
            new_slot = ~outstanding_shift &
                       ((outstanding_shift << 1) | {{(NUM_REQS-1){1'b0}}, 1'b1});
        end
        outstanding_d = outstanding_shift | new_slot;
        discard_d     = (branch_i ? outstanding_shift : discard_shift) |
                        (new_discard ? new_slot : '0);
    end

    assign fifo_clear_o = branch_i;
    assign fifo_addr_o  = addr_i;
    assign fifo_valid_o = rvalid_acc & ~discard_q[0] & ~branch_i;
    assign fifo_rdata_o = instr_rdata_i;
    assign fifo_err_o   = instr_err_i;
    assign busy_o       = (|outstanding_q) | instr_req_o;

    rvalid_needs_outstanding : assert property (
        @(posedge clk_i) disable iff (!rst_ni) instr_rvalid_i |-> outstanding_q[0]);

    req_held_until_gnt : assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        (instr_req_o && !instr_gnt_i) |=> (instr_req_o && $stable(instr_addr_o)));

endmodule

// File: tb/tb_ibex_fetch_req_engine.sv
// Directed bench for ibex_fetch_req_engine: queue-based transaction model checked every
// cycle, plus hand-computed literal expectations for each scenario.
module tb_ibex_fetch_req_engine;

    localparam int N = 2;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          req_i, branch_i;
    logic [31:0]   addr_i;
    logic          busy_o;
    logic [N-1:0]  fifo_busy_i;
    logic          fifo_clear_o, fifo_valid_o, fifo_err_o;
    logic [31:0]   fifo_addr_o, fifo_rdata_o;
    logic          instr_req_o, instr_gnt_i;
    logic [31:0]   instr_addr_o;
    logic          instr_rvalid_i, instr_err_i;
    logic [31:0]   instr_rdata_i;

    int errors = 0;
    int checks = 0;

    ibex_fetch_req_engine #(.NUM_REQS(N)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .req_i          (req_i),
        .branch_i       (branch_i),
        .addr_i         (addr_i),
        .busy_o         (busy_o),
        .fifo_busy_i    (fifo_busy_i),
        .fifo_clear_o   (fifo_clear_o),
        .fifo_valid_o   (fifo_valid_o),
        .fifo_addr_o    (fifo_addr_o),
        .fifo_rdata_o   (fifo_rdata_o),
        .fifo_err_o     (fifo_err_o),
        .instr_req_o    (instr_req_o),
        .instr_gnt_i    (instr_gnt_i),
        .instr_addr_o   (instr_addr_o),
        .instr_rvalid_i (instr_rvalid_i),
        .instr_rdata_i  (instr_rdata_i),
        .instr_err_i    (instr_err_i)
    );

    always #5 clk_i = ~clk_i;

    // Transaction-level model: one stale flag per outstanding fetch, oldest first.
    bit          m_stale[$];
    logic [31:0] m_next;
    bit          m_wait;
    logic [31:0] m_wait_addr;
    bit          m_wait_stale;
    bit          m_redir_v;
    logic [31:0] m_redir;

    function automatic void predict(output bit p_req, output logic [31:0] p_addr,
                                    output bit p_valid);
        int live;
        bit popping;
        live    = m_stale.size();
        popping = instr_rvalid_i && (live > 0);
        if (m_wait) begin
            p_req  = 1'b1;
            p_addr = m_wait_addr;
        end else begin
            p_addr = branch_i ? (addr_i & 32'hFFFF_FFFC) : (m_redir_v ? m_redir : m_next);
            p_req  = req_i && ((fifo_busy_i != {N{1'b1}}) || branch_i) &&
                     ((live - (popping ? 1 : 0)) < N);
        end
        p_valid = popping && !m_stale[0] && !branch_i;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    initial begin : model_update
        bit          p_req, p_valid, was_wait, granted;
        logic [31:0] p_addr;
        forever begin
            @(posedge clk_i or negedge rst_ni);
            if (!rst_ni) begin
                m_stale.delete();
                m_next       = '0;
                m_wait       = 1'b0;
                m_wait_addr  = '0;
                m_wait_stale = 1'b0;
                m_redir_v    = 1'b0;
                m_redir      = '0;
            end else begin
                predict(p_req, p_addr, p_valid);
                was_wait = m_wait;
                granted  = p_req && instr_gnt_i;
                if (instr_rvalid_i && m_stale.size() > 0) void'(m_stale.pop_front());
                if (branch_i) foreach (m_stale[i]) m_stale[i] = 1'b1;
                if (granted) begin
                    m_stale.push_back(was_wait && (m_wait_stale || branch_i));
                    m_next = p_addr + 32'd4;
                    m_wait = 1'b0;
                    if (!was_wait) m_redir_v = 1'b0;
                end else if (p_req && !was_wait) begin
                    m_wait       = 1'b1;
                    m_wait_addr  = p_addr;
                    m_wait_stale = 1'b0;
                    m_redir_v    = 1'b0;
                end
                if (branch_i && (was_wait || !p_req)) begin
                    m_redir_v = 1'b1;
                    m_redir   = addr_i & 32'hFFFF_FFFC;
                    if (was_wait && !instr_gnt_i) m_wait_stale = 1'b1;
                end
            end
        end
    end

    initial begin : compare
        bit          p_req, p_valid;
        logic [31:0] p_addr;
        forever begin
            @(negedge clk_i);
            if (rst_ni) begin
                predict(p_req, p_addr, p_valid);
                checkOutput("instr_req", 32'(instr_req_o), 32'(p_req));
                if (p_req) checkOutput("instr_addr", instr_addr_o, p_addr);
                checkOutput("fifo_valid", 32'(fifo_valid_o), 32'(p_valid));
                checkOutput("fifo_clear", 32'(fifo_clear_o), 32'(branch_i));
                checkOutput("fifo_addr", fifo_addr_o, addr_i);
                checkOutput("fifo_rdata", fifo_rdata_o, instr_rdata_i);
                checkOutput("fifo_err", 32'(fifo_err_o), 32'(instr_err_i));
                checkOutput("busy", 32'(busy_o), 32'((m_stale.size() > 0) || p_req));
            end
        end
    end

    task automatic applyStimulus(input bit req, input bit br, input logic [31:0] a,
                                 input logic [1:0] fb, input bit g, input bit rv,
                                 input logic [31:0] rd, input bit er);
        @(posedge clk_i);
        #1;
        req_i          = req;
        branch_i       = br;
        addr_i         = a;
        fifo_busy_i    = fb;
        instr_gnt_i    = g;
        instr_rvalid_i = rv;
        instr_rdata_i  = rd;
        instr_err_i    = er;
        @(negedge clk_i);
        #1;
    endtask

    task automatic idleCycle();
        applyStimulus(0, 0, 32'h0, 2'b00, 0, 0, 32'h0, 0);
    endtask

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        req_i = 0; branch_i = 0; addr_i = '0; fifo_busy_i = '0;
        instr_gnt_i = 0; instr_rvalid_i = 0; instr_rdata_i = '0; instr_err_i = 0;
        rst_ni = 1'b0;
        repeat (2) @(negedge clk_i);
        checkOutput("reset_req", 32'(instr_req_o), 32'h0);
        checkOutput("reset_busy", 32'(busy_o), 32'h0);
        checkOutput("reset_valid", 32'(fifo_valid_o), 32'h0);
        checkOutput("reset_addr", instr_addr_o, 32'h0);
        @(posedge clk_i);
        #1 rst_ni = 1'b1;

        $display("[TB] sequential fetch after branch to 0x100");
        applyStimulus(1, 1, 32'h100, 2'b00, 1, 0, 32'h0, 0);
        checkOutput("seq_addr0", instr_addr_o, 32'h100);
        checkOutput("seq_clear", 32'(fifo_clear_o), 32'h1);
        applyStimulus(1, 0, 32'h0, 2'b00, 1, 1, 32'hA000_0000, 0);
        checkOutput("seq_addr1", instr_addr_o, 32'h104);
        checkOutput("seq_push0", 32'(fifo_valid_o), 32'h1);
        applyStimulus(1, 0, 32'h0, 2'b00, 1, 1, 32'hA000_0001, 0);
        checkOutput("seq_addr2", instr_addr_o, 32'h108);
        applyStimulus(0, 0, 32'h0, 2'b00, 0, 1, 32'hA000_0002, 0);
        checkOutput("seq_push2", 32'(fifo_valid_o), 32'h1);
        idleCycle();
        checkOutput("seq_busy_end", 32'(busy_o), 32'h0);

        $display("[TB] grant backpressure with branch to 0x200");
        applyStimulus(1, 0, 32'h0, 2'b00, 0, 0, 32'h0, 0);
        checkOutput("bp_addr_c1", instr_addr_o, 32'h10C);
        applyStimulus(1, 1, 32'h200, 2'b00, 0, 0, 32'h0, 0);
        checkOutput("bp_addr_c2", instr_addr_o, 32'h10C);
        applyStimulus(0, 0, 32'h0, 2'b00, 0, 0, 32'h0, 0);
        checkOutput("bp_req_held", 32'(instr_req_o), 32'h1);
        checkOutput("bp_addr_c3", instr_addr_o, 32'h10C);
        applyStimulus(1, 0, 32'h0, 2'b00, 1, 0, 32'h0, 0);
        applyStimulus(1, 0, 32'h0, 2'b00, 1, 1, 32'hBAD0_0000, 0);
        checkOutput("bp_drop_stale", 32'(fifo_valid_o), 32'h0);
        checkOutput("bp_target", instr_addr_o, 32'h200);
        applyStimulus(0, 0, 32'h0, 2'b00, 0, 1, 32'hB000_0200, 0);
        checkOutput("bp_push_target", 32'(fifo_valid_o), 32'h1);
        idleCycle();

        $display("[TB] outstanding limit");
        applyStimulus(1, 0, 32'h0, 2'b00, 1, 0, 32'h0, 0);
        checkOutput("lim_addr0", instr_addr_o, 32'h204);
        applyStimulus(1, 0, 32'h0, 2'b00, 1, 0, 32'h0, 0);
        applyStimulus(1, 0, 32'h0, 2'b00, 1, 0, 32'h0, 0);
        checkOutput("lim_full_noreq", 32'(instr_req_o), 32'h0);
        checkOutput("lim_full_busy", 32'(busy_o), 32'h1);
        applyStimulus(1, 0, 32'h0, 2'b00, 1, 1, 32'hC000_0204, 0);
        checkOutput("lim_reissue", 32'(instr_req_o), 32'h1);
        checkOutput("lim_reissue_addr", instr_addr_o, 32'h20C);
        applyStimulus(0, 0, 32'h0, 2'b00, 0, 1, 32'hC000_0208, 0);
        applyStimulus(0, 0, 32'h0, 2'b00, 0, 1, 32'hC000_020C, 0);
        idleCycle();
        checkOutput("lim_busy_end", 32'(busy_o), 32'h0);

        $display("[TB] stale discard with branch to 0x40");
        applyStimulus(1, 0, 32'h0, 2'b00, 1, 0, 32'h0, 0);
        applyStimulus(1, 0, 32'h0, 2'b00, 1, 0, 32'h0, 0);
        applyStimulus(1, 1, 32'h40, 2'b00, 1, 0, 32'h0, 0);
        checkOutput("disc_full_branch", 32'(instr_req_o), 32'h0);
        applyStimulus(1, 0, 32'h0, 2'b00, 1, 1, 32'hDEAD_0210, 0);
        checkOutput("disc_drop0", 32'(fifo_valid_o), 32'h0);
        checkOutput("disc_target", instr_addr_o, 32'h40);
        applyStimulus(0, 0, 32'h0, 2'b00, 0, 1, 32'hDEAD_0214, 0);
        checkOutput("disc_drop1", 32'(fifo_valid_o), 32'h0);
        applyStimulus(0, 0, 32'h0, 2'b00, 0, 1, 32'h0000_0040, 0);
        checkOutput("disc_push_target", 32'(fifo_valid_o), 32'h1);
        idleCycle();
        checkOutput("disc_busy_end", 32'(busy_o), 32'h0);

        $display("[TB] fifo full blocks sequential issue, branch overrides");
        applyStimulus(1, 0, 32'h0, 2'b11, 1, 0, 32'h0, 0);
        checkOutput("ff_block", 32'(instr_req_o), 32'h0);
        applyStimulus(1, 1, 32'h82, 2'b11, 1, 0, 32'h0, 0);
        checkOutput("ff_branch_req", 32'(instr_req_o), 32'h1);
        checkOutput("ff_branch_addr", instr_addr_o, 32'h80);
        checkOutput("ff_fifo_addr", fifo_addr_o, 32'h82);
        applyStimulus(0, 0, 32'h0, 2'b11, 0, 1, 32'h1234_5678, 0);
        checkOutput("ff_push", 32'(fifo_valid_o), 32'h1);
        idleCycle();

        $display("[TB] bus error and address wrap");
        applyStimulus(1, 1, 32'hFFFF_FFFC, 2'b00, 1, 0, 32'h0, 0);
        checkOutput("wrap_addr", instr_addr_o, 32'hFFFF_FFFC);
        applyStimulus(1, 0, 32'h0, 2'b00, 1, 1, 32'h0000_DEAD, 1);
        checkOutput("wrap_next", instr_addr_o, 32'h0);
        checkOutput("err_push", 32'(fifo_valid_o), 32'h1);
        checkOutput("err_flag", 32'(fifo_err_o), 32'h1);
        applyStimulus(0, 0, 32'h0, 2'b00, 0, 1, 32'h0000_0001, 0);
        idleCycle();

        $display("[TB] reset with a transaction outstanding");
        applyStimulus(1, 0, 32'h0, 2'b00, 1, 0, 32'h0, 0);
        req_i = 0; instr_gnt_i = 0;
        rst_ni = 1'b0;
        #1;
        checkOutput("rst_mid_busy", 32'(busy_o), 32'h0);
        checkOutput("rst_mid_req", 32'(instr_req_o), 32'h0);
        @(posedge clk_i);
        #1 rst_ni = 1'b1;
        applyStimulus(1, 0, 32'h0, 2'b00, 1, 0, 32'h0, 0);
        checkOutput("rst_restart_addr", instr_addr_o, 32'h0);
        applyStimulus(0, 0, 32'h0, 2'b00, 0, 1, 32'h5555_0000, 0);
        checkOutput("rst_restart_push", 32'(fifo_valid_o), 32'h1);
        idleCycle();
        idleCycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
